ac_motor_ramp_ctrl: RTL and testbench
=====================================

Name: ac_motor_ramp_ctrl

Overview:
Command sequencer placed in front of the AC_MOTOR drive. It accepts direction/frequency/amplitude commands through a valid/ready handshake and drives AC_MOTOR's enable, cw, ccw, frequency and amplitude inputs. It applies soft-start and soft-stop ramps and a dead-time on reversal. It also trips on overcurrent, using ADC samples strobed by AC_MOTOR's adc_latch.

Parameters:
STEP_DIV, 1000, clocks per ramp tick (>=1)
STEP, 1, increment/decrement applied to frequency and amplitude per tick
DEAD_CYCLES, 500, clocks with both bridges off between direction reversal stages
TRIP_COUNT, 3, consecutive over-threshold ADC samples that cause a fault

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_dir  in  2  01=cw, 10=ccw, 00 or 11=stop
cmd_frequency  in  12  target frequency (unsigned)
cmd_amplitude  in  12  target amplitude (unsigned)
adc  in  12  current ADC value from motor sense
adc_latch  in  1  AC_MOTOR sample strobe, synchronous to clk
adc_cmp  in  12  overcurrent threshold (unsigned)
fault_clr  in  1  clears FAULT
enable  out  1  to AC_MOTOR enable
cw  out  1  to AC_MOTOR cw
ccw  out  1  to AC_MOTOR ccw
frequency  out  12  to AC_MOTOR frequency
amplitude  out  12  to AC_MOTOR amplitude
fault  out  1  high in FAULT
busy  out  1  high in any state other than IDLE and RUN

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All registers are cleared immediately on reset, including mid-ramp.
- Reset values: enable=0, cw=0, ccw=0, frequency=0, amplitude=0, fault=0, busy=0, cmd_ready=1, state=IDLE. Prescaler, dead counter and trip counter are all 0.
- Outputs are registered. An accept at edge N updates cw/ccw/enable at edge N. The first ramp step occurs at the next tick.
- Prescaler: free-running counter 0..STEP_DIV-1. A tick occurs on the clock where it equals STEP_DIV-1.
- Ramp arithmetic: on each tick, each of frequency and amplitude independently moves toward its target by STEP, clamped to the target. Computation is in 13 bits, so there is no overshoot and no wrap. Never exceeds 4095; never goes below 0.
- cmd_ready=1 in IDLE, RAMP and RUN; 0 in RAMP_DOWN, DEAD and FAULT.
- States:
  - IDLE: on accept with cw or ccw and cmd_frequency!=0, set cw/ccw, set enable=1, load targets, go to RAMP. Stop commands, and commands with frequency 0, are accepted with no effect.
  - RAMP: on reaching both targets, go to RUN. An accept in the same direction reloads the targets and stays in RAMP.
  - RUN: an accept in the same direction reloads the targets and goes to RAMP. An accept in the other direction, or a stop, stores the pending command, sets targets to 0,0 and goes to RAMP_DOWN.
  - RAMP_DOWN: when frequency=0 and amplitude=0:
    - pending stop: go to IDLE with enable=cw=ccw=0.
    - pending reverse: go to DEAD with enable=cw=ccw=0.
  - DEAD: counts DEAD_CYCLES clocks. Then sets the new direction and enable=1, loads the pending targets, and goes to RAMP.
  - FAULT: enable, cw, ccw, frequency and amplitude are forced to 0 on the entry edge; fault=1. A fault_clr pulse goes to IDLE and clears fault. fault_clr is ignored in all other states.
- Overcurrent detection:
  - An ADC sample is taken on the rising edge of adc_latch (registered previous value), only while enable=1.
  - A sample with adc>adc_cmp (unsigned) increments the trip counter; a sample with adc<=adc_cmp clears it.
  - Reaching TRIP_COUNT causes FAULT on the next edge, from any state.
  - The trip counter clears in IDLE, DEAD and FAULT.
- Simultaneous events:
  - Trip and command accept on the same cycle: the fault wins and the command is discarded.
  - Tick and accept on the same cycle: the new target applies, and the tick steps toward the new target.

Test Plan:
All scenarios use STEP_DIV=4, STEP=100, DEAD_CYCLES=10, TRIP_COUNT=3.
1. Reset asserted -> all outputs 0, cmd_ready=1, busy=0. Release, then hold idle 20 clocks -> outputs unchanged.
2. cmd cw, freq 1000, amp 250 -> cw=1, enable=1 on the accept edge. Frequency steps 100,200..1000 every 4 clocks; amplitude steps 100,200,250 then holds. busy falls after the 10th tick.
3. In RUN, cmd ccw 500/500 -> cmd_ready=0, ramp down to 0/0. Then enable=cw=ccw=0 for exactly 10 clocks, then ccw=1, enable=1, ramp to 500/500.
4. adc_cmp=3000, adc=4000 on 3 consecutive latches -> fault=1 and all drive outputs 0 one clock after the 3rd latch. Separately, the pattern 4000,4000,1000,4000 -> no fault. fault_clr in FAULT -> IDLE.
5. In RUN, cmd dir 00 -> ramp to 0/0, then IDLE with enable=0. A subsequent cmd freq 0 is accepted with no output change.
6. reset_n low mid-RAMP, asynchronous to clk -> outputs 0 before the next clock edge; state IDLE after release.

Source files
------------

// File: rtl/ac_motor_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ac_motor_ramp_ctrl
// Description : Command sequencer for the AC_MOTOR drive. It applies soft-start
//               and soft-stop ramps, a dead-time on reversal, and an
//               overcurrent trip.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_ramp_ctrl #(
  parameter int STEP_DIV    = 1000,
  parameter int STEP        = 1,
  parameter int DEAD_CYCLES = 500,
  parameter int TRIP_COUNT  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_dir,
  input  logic [11:0] cmd_frequency,
  input  logic [11:0] cmd_amplitude,
  input  logic [11:0] adc,
  input  logic        adc_latch,
  input  logic [11:0] adc_cmp,
  input  logic        fault_clr,
  output logic        enable,
  output logic        cw,
  output logic        ccw,
  output logic [11:0] frequency,
  output logic [11:0] amplitude,
  output logic        fault,
  output logic        busy
);

  localparam int c_pre_w  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int c_dead_w = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int c_trip_w = $clog2(TRIP_COUNT + 1);

  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(STEP_DIV - 1);
  localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_CYCLES - 1);
  localparam logic [c_trip_w-1:0] c_trip_lim  = c_trip_w'(TRIP_COUNT);
  localparam logic [12:0]         c_step      = 13'(STEP);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP      = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_DEAD      = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic [2:0]          r_state, w_state_nxt;
  logic [c_pre_w-1:0]  r_pre, w_pre_nxt;
  logic [c_dead_w-1:0] r_dead, w_dead_nxt;
  logic [c_trip_w-1:0] r_trip, w_trip_nxt;
  logic                r_latch_d;
  logic                r_enable, w_enable_nxt;
  logic                r_cw, w_cw_nxt;
  logic                r_ccw, w_ccw_nxt;
  logic [11:0]         r_freq, w_freq_nxt;
  logic [11:0]         r_amp, w_amp_nxt;
  logic [11:0]         r_tgt_f, w_tgt_f_nxt;
  logic [11:0]         r_tgt_a, w_tgt_a_nxt;
  logic [11:0]         r_pend_f, w_pend_f_nxt;
  logic [11:0]         r_pend_a, w_pend_a_nxt;
  logic [1:0]          r_pend_dir, w_pend_dir_nxt;

  logic w_tick, w_accept, w_trip, w_sample, w_over;
  logic w_cmd_cw, w_cmd_ccw, w_cmd_run, w_same_dir, w_pend_run, w_at_zero;

  assign w_tick     = (r_pre == c_pre_last);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_trip     = (r_trip == c_trip_lim);
  assign w_sample   = adc_latch && !r_latch_d && r_enable;
  assign w_over     = (adc > adc_cmp);
  assign w_cmd_cw   = (cmd_dir == 2'b01);
  assign w_cmd_ccw  = (cmd_dir == 2'b10);
  assign w_cmd_run  = w_cmd_cw || w_cmd_ccw;
  assign w_same_dir = (w_cmd_cw && r_cw) || (w_cmd_ccw && r_ccw);
  assign w_pend_run = (r_pend_dir == 2'b01) || (r_pend_dir == 2'b10);
  assign w_at_zero  = (r_freq == 12'd0) && (r_amp == 12'd0);

  // One ramp step toward the target; 13-bit math keeps it clamped and wrap-free.
  function automatic logic [11:0] f_ramp(input logic [11:0] cur, input logic [11:0] tgt);
    logic [12:0] w_cur, w_tgt, w_res;
    w_cur = {1'b0, cur};
    w_tgt = {1'b0, tgt};
    w_res = w_tgt;
    if (w_cur < w_tgt) begin
      if ((w_tgt - w_cur) > c_step) w_res = w_cur + c_step;
    end else if (w_cur > w_tgt) begin
      if ((w_cur - w_tgt) > c_step) w_res = w_cur - c_step;
    end
    return w_res[11:0];
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_dead     <= '0;
      r_trip     <= '0;
      r_latch_d  <= 1'b0;
      r_enable   <= 1'b0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_freq     <= '0;
      r_amp      <= '0;
      r_tgt_f    <= '0;
      r_tgt_a    <= '0;
      r_pend_f   <= '0;
      r_pend_a   <= '0;
      r_pend_dir <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre      <= w_pre_nxt;
      r_dead     <= w_dead_nxt;
      r_trip     <= w_trip_nxt;
      r_latch_d  <= adc_latch;
      r_enable   <= w_enable_nxt;
      r_cw       <= w_cw_nxt;
      r_ccw      <= w_ccw_nxt;
      r_freq     <= w_freq_nxt;
      r_amp      <= w_amp_nxt;
      r_tgt_f    <= w_tgt_f_nxt;
      r_tgt_a    <= w_tgt_a_nxt;
      r_pend_f   <= w_pend_f_nxt;
      r_pend_a   <= w_pend_a_nxt;
      r_pend_dir <= w_pend_dir_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_trip) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_cmd_run && (cmd_frequency != 12'd0)) w_state_nxt = S_RAMP;
        end
        S_RAMP: begin
          if (w_accept && w_same_dir) w_state_nxt = S_RAMP;
          else if (w_accept) w_state_nxt = S_RAMP_DOWN;
          else if ((w_freq_nxt == r_tgt_f) && (w_amp_nxt == r_tgt_a)) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_accept && w_same_dir) w_state_nxt = S_RAMP;
          else if (w_accept) w_state_nxt = S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (w_at_zero) w_state_nxt = w_pend_run ? S_DEAD : S_IDLE;
        end
        S_DEAD: begin
          if (r_dead == c_dead_last) w_state_nxt = S_RAMP;
        end
        S_FAULT: begin
          if (fault_clr) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    w_pre_nxt      = w_tick ? '0 : r_pre + 1'b1;
    w_dead_nxt     = '0;
    w_enable_nxt   = r_enable;
    w_cw_nxt       = r_cw;
    w_ccw_nxt      = r_ccw;
    w_tgt_f_nxt    = r_tgt_f;
    w_tgt_a_nxt    = r_tgt_a;
    w_pend_f_nxt   = r_pend_f;
    w_pend_a_nxt   = r_pend_a;
    w_pend_dir_nxt = r_pend_dir;

    case (r_state)
      S_IDLE: begin
        if (w_accept && w_cmd_run && (cmd_frequency != 12'd0)) begin
          w_enable_nxt = 1'b1;
          w_cw_nxt     = w_cmd_cw;
          w_ccw_nxt    = w_cmd_ccw;
          w_tgt_f_nxt  = cmd_frequency;
          w_tgt_a_nxt  = cmd_amplitude;
        end
      end
      S_RAMP, S_RUN: begin
        if (w_accept && w_same_dir) begin
          w_tgt_f_nxt = cmd_frequency;
          w_tgt_a_nxt = cmd_amplitude;
        end else if (w_accept) begin
          w_pend_dir_nxt = cmd_dir;
          w_pend_f_nxt   = cmd_frequency;
          w_pend_a_nxt   = cmd_amplitude;
          w_tgt_f_nxt    = '0;
          w_tgt_a_nxt    = '0;
        end
      end
      S_RAMP_DOWN: begin
        if (w_at_zero) begin
          w_enable_nxt = 1'b0;
          w_cw_nxt     = 1'b0;
          w_ccw_nxt    = 1'b0;
        end
      end
      S_DEAD: begin
        w_dead_nxt = r_dead + 1'b1;
        if (r_dead == c_dead_last) begin
          w_dead_nxt   = '0;
          w_enable_nxt = 1'b1;
          w_cw_nxt     = (r_pend_dir == 2'b01);
          w_ccw_nxt    = (r_pend_dir == 2'b10);
          w_tgt_f_nxt  = r_pend_f;
          w_tgt_a_nxt  = r_pend_a;
        end
      end
      default: ;
    endcase

    // Step toward the target as it will be after this edge
    w_freq_nxt = w_tick ? f_ramp(r_freq, w_tgt_f_nxt) : r_freq;
    w_amp_nxt  = w_tick ? f_ramp(r_amp, w_tgt_a_nxt) : r_amp;

    if (w_trip) begin
      w_enable_nxt = 1'b0;
      w_cw_nxt     = 1'b0;
      w_ccw_nxt    = 1'b0;
      w_freq_nxt   = '0;
      w_amp_nxt    = '0;
      w_tgt_f_nxt  = '0;
      w_tgt_a_nxt  = '0;
      w_dead_nxt   = '0;
    end

    w_trip_nxt = r_trip;
    if (w_trip || (r_state == S_IDLE) || (r_state == S_DEAD) || (r_state == S_FAULT))
      w_trip_nxt = '0;
    else if (w_sample)
      w_trip_nxt = w_over ? r_trip + 1'b1 : '0;
  end

  assign enable    = r_enable;
  assign cw        = r_cw;
  assign ccw       = r_ccw;
  assign frequency = r_freq;
  assign amplitude = r_amp;
  assign fault     = (r_state == S_FAULT);
  assign busy      = (r_state != S_IDLE) && (r_state != S_RUN);
  assign cmd_ready = (r_state == S_IDLE) || (r_state == S_RAMP) || (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ac_motor_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ac_motor_ramp_ctrl
// Description : Directed self-checking bench for ac_motor_ramp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ac_motor_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_dir = 2'b00;
  logic [11:0] cmd_frequency = '0;
  logic [11:0] cmd_amplitude = '0;
  logic [11:0] adc = '0;
  logic        adc_latch = 1'b0;
  logic [11:0] adc_cmp = 12'd3000;
  logic        fault_clr = 1'b0;
  logic        enable, cw, ccw, fault, busy;
  logic [11:0] frequency, amplitude;

  int errors = 0;
  int checks = 0;

  ac_motor_ramp_ctrl #(
    .STEP_DIV(4), .STEP(100), .DEAD_CYCLES(10), .TRIP_COUNT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_frequency(cmd_frequency), .cmd_amplitude(cmd_amplitude),
    .adc(adc), .adc_latch(adc_latch), .adc_cmp(adc_cmp), .fault_clr(fault_clr),
    .enable(enable), .cw(cw), .ccw(ccw), .frequency(frequency),
    .amplitude(amplitude), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_freq(input logic [11:0] v, output int n);
    n = 0;
    while ((frequency !== v) && (n < 8)) begin
      step();
      n++;
    end
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [11:0] f, input logic [11:0] a);
    cmd_valid = 1'b1; cmd_dir = d; cmd_frequency = f; cmd_amplitude = a;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic latch_pulse(input logic [11:0] v);
    adc = v; adc_latch = 1'b1;
    step();
    adc_latch = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({enable, cw, ccw, fault, busy, cmd_ready} !== 6'b000001 || frequency !== 12'd0 || amplitude !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: en/cw/ccw/fault/busy/rdy=%b f=%0d a=%0d expected 000001 0 0",
               {enable, cw, ccw, fault, busy, cmd_ready}, frequency, amplitude);
    end
    repeat (3) step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({enable, cw, ccw, fault, busy, cmd_ready} !== 6'b000001 || frequency !== 12'd0 || amplitude !== 12'd0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: flags=%b f=%0d a=%0d expected 000001 0 0",
                 i, {enable, cw, ccw, fault, busy, cmd_ready}, frequency, amplitude);
      end
    end
  endtask

  task automatic test_ramp_up();
    int n;
    logic [11:0] ef, ea;
    send_cmd(2'b01, 12'd1000, 12'd250);
    checks++;
    if ({enable, cw, ccw, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL accept_cw: en/cw/ccw/busy=%b expected 1101", {enable, cw, ccw, busy});
    end
    for (int k = 1; k <= 10; k++) begin
      ef = 12'(100 * k);
      ea = (k < 3) ? 12'(100 * k) : 12'd250;
      wait_freq(ef, n);
      checks++;
      if (frequency !== ef || amplitude !== ea) begin
        errors++;
        $display("FAIL ramp_up_step%0d: f=%0d a=%0d expected f=%0d a=%0d", k, frequency, amplitude, ef, ea);
      end
      if (k > 1) begin
        checks++;
        if (n !== 4) begin
          errors++;
          $display("FAIL ramp_up_interval%0d: clocks=%0d expected 4", k, n);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL ramp_busy: busy=%b expected 1", busy);
        end
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || frequency !== 12'd1000 || amplitude !== 12'd250) begin
      errors++;
      $display("FAIL run_reached: busy=%b f=%0d a=%0d expected 0 1000 250", busy, frequency, amplitude);
    end
  endtask

  task automatic test_reverse();
    int n;
    int dead;
    logic [11:0] ef, ea;
    send_cmd(2'b10, 12'd500, 12'd500);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reverse_accept: rdy=%b busy=%b expected 0 1", cmd_ready, busy);
    end
    for (int k = 1; k <= 10; k++) begin
      ef = 12'(1000 - 100 * k);
      ea = (k < 3) ? 12'(250 - 100 * k) : 12'd0;
      wait_freq(ef, n);
      checks++;
      if (frequency !== ef || amplitude !== ea) begin
        errors++;
        $display("FAIL ramp_down_step%0d: f=%0d a=%0d expected f=%0d a=%0d", k, frequency, amplitude, ef, ea);
      end
    end
    n = 0;
    while (enable !== 1'b0 && n < 3) begin step(); n++; end
    checks++;
    if (enable !== 1'b0 || cw !== 1'b0 || ccw !== 1'b0) begin
      errors++;
      $display("FAIL dead_entry: en/cw/ccw=%b expected 000", {enable, cw, ccw});
    end
    dead = 0;
    while (enable === 1'b0 && dead < 20) begin dead++; step(); end
    checks++;
    if (dead !== 10) begin
      errors++;
      $display("FAIL dead_time: clocks=%0d expected 10", dead);
    end
    checks++;
    if (ccw !== 1'b1 || cw !== 1'b0) begin
      errors++;
      $display("FAIL reverse_dir: cw/ccw=%b expected 01", {cw, ccw});
    end
    for (int k = 1; k <= 5; k++) begin
      ef = 12'(100 * k);
      wait_freq(ef, n);
      checks++;
      if (frequency !== ef || amplitude !== ef) begin
        errors++;
        $display("FAIL reverse_ramp%0d: f=%0d a=%0d expected %0d %0d", k, frequency, amplitude, ef, ef);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reverse_run: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fault();
    int n;
    adc_cmp = 12'd3000;
    repeat (3) latch_pulse(12'd4000);
    checks++;
    if (fault !== 1'b1 || {enable, cw, ccw} !== 3'b000 || frequency !== 12'd0 || amplitude !== 12'd0) begin
      errors++;
      $display("FAIL trip: fault=%b en/cw/ccw=%b f=%0d a=%0d expected 1 000 0 0",
               fault, {enable, cw, ccw}, frequency, amplitude);
    end
    repeat (3) step();
    checks++;
    if (fault !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: fault=%b rdy=%b busy=%b expected 1 0 1", fault, cmd_ready, busy);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fault_clear: fault=%b busy=%b rdy=%b expected 0 0 1", fault, busy, cmd_ready);
    end
    send_cmd(2'b01, 12'd300, 12'd300);
    latch_pulse(12'd4000);
    latch_pulse(12'd4000);
    latch_pulse(12'd1000);
    latch_pulse(12'd4000);
    repeat (3) step();
    checks++;
    if (fault !== 1'b0 || enable !== 1'b1) begin
      errors++;
      $display("FAIL no_trip_pattern: fault=%b en=%b expected 0 1", fault, enable);
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin step(); n++; end
    checks++;
    if (busy !== 1'b0 || frequency !== 12'd300 || amplitude !== 12'd300) begin
      errors++;
      $display("FAIL resume_run: busy=%b f=%0d a=%0d expected 0 300 300", busy, frequency, amplitude);
    end
  endtask

  task automatic test_stop();
    int n;
    send_cmd(2'b00, 12'd0, 12'd0);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL stop_accept: rdy=%b expected 0", cmd_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_freq(12'(300 - 100 * k), n);
      checks++;
      if (frequency !== 12'(300 - 100 * k) || amplitude !== 12'(300 - 100 * k) || enable !== 1'b1) begin
        errors++;
        $display("FAIL stop_ramp%0d: f=%0d a=%0d en=%b expected %0d %0d 1",
                 k, frequency, amplitude, enable, 300 - 100 * k, 300 - 100 * k);
      end
    end
    n = 0;
    while (enable !== 1'b0 && n < 3) begin step(); n++; end
    checks++;
    if ({enable, cw, ccw, busy, cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL stop_idle: en/cw/ccw/busy/rdy=%b expected 00001", {enable, cw, ccw, busy, cmd_ready});
    end
    send_cmd(2'b01, 12'd0, 12'd200);
    repeat (5) step();
    checks++;
    if ({enable, cw, ccw, busy, cmd_ready} !== 5'b00001 || frequency !== 12'd0 || amplitude !== 12'd0) begin
      errors++;
      $display("FAIL zero_freq_cmd: flags=%b f=%0d a=%0d expected 00001 0 0",
               {enable, cw, ccw, busy, cmd_ready}, frequency, amplitude);
    end
  endtask

  task automatic test_async_reset();
    int n;
    send_cmd(2'b01, 12'd1000, 12'd1000);
    wait_freq(12'd300, n);
    checks++;
    if (frequency !== 12'd300 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ramp: f=%0d busy=%b expected 300 1", frequency, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({enable, cw, ccw, fault, busy, cmd_ready} !== 6'b000001 || frequency !== 12'd0 || amplitude !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b f=%0d a=%0d expected 000001 0 0",
               {enable, cw, ccw, fault, busy, cmd_ready}, frequency, amplitude);
    end
    step();
    reset_n = 1'b1;
    repeat (6) step();
    checks++;
    if ({enable, busy, cmd_ready} !== 3'b001 || frequency !== 12'd0) begin
      errors++;
      $display("FAIL post_reset_idle: en/busy/rdy=%b f=%0d expected 001 0", {enable, busy, cmd_ready}, frequency);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reverse();
    test_fault();
    test_stop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
